// File: rtl/vscpu_mc.sv
// rtl/vscpu_mc.sv - multi-cycle VSCPU core with req/ack memory port and halt/retire status.
// Optional multiplier: define VSCPU_MUL_EN to execute MUL/MULi; otherwise they retire as illegal.
module vscpu_mc #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              retired,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD_A, S_RD_B, S_RD_IND, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_CPI  = 4'd10;
  localparam logic [3:0] OP_CPII = 4'd11;
  localparam logic [3:0] OP_BZJ  = 4'd12;
  localparam logic [3:0] OP_BZJI = 4'd13;

  state_t            state, state_n;
  logic [DATA_W-1:0] iw, a_val, b_val;
  logic [ADDR_W-1:0] pc_n, target;
  logic              ret_n, ill_n;
  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, result, opnd, b_imm, mul_res;
  logic              do_branch;

  wire  [3:0]        op    = iw[DATA_W-1 -: 4];
  wire  [ADDR_W-1:0] fa    = iw[2*ADDR_W-1:ADDR_W];
  wire  [ADDR_W-1:0] fb    = iw[ADDR_W-1:0];
  wire  [3:0]        f_op  = mem_rdata[DATA_W-1 -: 4];
  wire  [ADDR_W-1:0] pc_p1 = pc + ADDR_W'(1);
  wire               imm_alu = op[0] && (!op[3] || op == 4'd15);

  assign b_imm = {{(DATA_W-ADDR_W){1'b0}}, fb};
  assign opnd  = op[0] ? b_imm : b_val;

`ifdef VSCPU_MUL_EN
  assign mul_res = a_val * opnd;
`else
  assign mul_res = '0;
`endif

  always_comb begin
    result = '0;
    case (op[3:1])
      3'd0: result = a_val + opnd;
      3'd1: result = ~(a_val & opnd);
      3'd2: result = (opnd < DATA_W'(DATA_W)) ? (a_val >> opnd)
                                               : (a_val << (opnd - DATA_W'(DATA_W)));
      3'd3: result = {{(DATA_W-1){1'b0}}, (a_val < opnd)};
      3'd4: result = opnd;
      3'd5: result = b_val;       // CPI: indirect word; CPIi: *B
      3'd7: result = mul_res;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ret_n     = 1'b0;
    ill_n     = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    target    = '0;
    do_branch = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        req  = 1'b1;
        addr = pc;
        if (mem_ack) begin
          case (f_op)
            4'd8, OP_CPI: state_n = S_RD_B;
            4'd9:         state_n = S_WB;
`ifndef VSCPU_MUL_EN
            4'd14, 4'd15: begin
              state_n = S_FETCH;
              pc_n    = pc_p1;
              ret_n   = 1'b1;
              ill_n   = 1'b1;
            end
`endif
            default:      state_n = S_RD_A;
          endcase
        end
      end
      S_RD_A: begin
        req  = 1'b1;
        addr = fa;
        if (mem_ack) begin
          if (op == OP_BZJI) begin
            target    = mem_rdata[ADDR_W-1:0] + fb;
            do_branch = 1'b1;
          end else if (imm_alu) begin
            state_n = S_WB;
          end else begin
            state_n = S_RD_B;
          end
        end
      end
      S_RD_B: begin
        req  = 1'b1;
        addr = fb;
        if (mem_ack) begin
          if (op == OP_BZJ) begin
            target    = (mem_rdata == '0) ? a_val[ADDR_W-1:0] : pc_p1;
            do_branch = 1'b1;
          end else if (op == OP_CPI) begin
            state_n = S_RD_IND;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_RD_IND: begin
        req  = 1'b1;
        addr = b_val[ADDR_W-1:0];
        if (mem_ack) state_n = S_WB;
      end
      S_WB: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = (op == OP_CPII) ? a_val[ADDR_W-1:0] : fa;
        wdata = result;
        if (mem_ack) begin
          pc_n    = pc_p1;
          ret_n   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    if (do_branch) begin
      pc_n    = target;
      ret_n   = 1'b1;
      state_n = (target == pc) ? S_HALT : S_FETCH;
    end
    // Reset drops the request combinationally so an ack in the same cycle cannot commit a write.
    if (rst) begin
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
    end
  end

  assign mem_req   = req;
  assign mem_we    = we;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      iw      <= '0;
      a_val   <= '0;
      b_val   <= '0;
      retired <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      retired <= ret_n;
      illegal <= ill_n;
      if (mem_req && mem_ack) begin
        case (state)
          S_FETCH:          iw    <= mem_rdata;
          S_RD_A:           a_val <= mem_rdata;
          S_RD_B, S_RD_IND: b_val <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vscpu_mc.sv
// tb/tb_vscpu_mc.sv - scoreboard bench for vscpu_mc with a wait-state memory model.
module tb_vscpu_mc;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          halted, retired, illegal;

  always #5 clk = ~clk;

  vscpu_mc #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .halted(halted), .retired(retired), .illegal(illegal)
  );

  logic [DW-1:0] mem [0:255];
  int  wait_cfg = 0;
  bit  block_wr = 1'b0;
  int  wcnt = 0;
  int  cyc = 0;

  assign mem_ack   = mem_req && (wcnt >= wait_cfg) && !(block_wr && mem_we);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] = mem_wdata;
    if (!mem_req || mem_ack) wcnt = 0;
    else wcnt = wcnt + 1;
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  fails = 0;
  int  last_wr_cyc = 0;

  logic          p_req = 1'b0, p_ack = 1'b0;
  logic [AW+DW:0] p_bus = '0;

  // Monitor: pops the expected write for every committed store and checks bus hold during waits.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_we && mem_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.a !== mem_addr || e.d !== mem_wdata) begin
          fails++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e.a, e.d);
        end
      end
      last_wr_cyc = cyc;
    end
    if (!rst && p_req && !p_ack && mem_req) begin
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== p_bus) begin
        fails++;
        $display("FAIL wait_hold got %h expected %h", {mem_we, mem_addr, mem_wdata}, p_bus);
      end
    end
    p_req = mem_req;
    p_ack = mem_ack;
    p_bus = {mem_we, mem_addr, mem_wdata};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input int a, input int b);
    return {op, a[13:0], b[13:0]};
  endfunction

  task automatic push(input int a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a[AW-1:0];
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  int c0;
  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    c0  = cyc;
  endtask

  task automatic stop();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Waits for n retire pulses; ill returns how many of them also flagged illegal.
  task automatic run(input int n, output int ill);
    int r;
    r   = 0;
    ill = 0;
    for (int k = 0; k < 500 && r < n; k++) begin
      @(negedge clk);
      if (retired) r++;
      if (illegal) ill++;
    end
    if (r < n) begin
      checks++;
      fails++;
      $display("FAIL run_timeout got %0d retires expected %0d", r, n);
    end
  endtask

  task automatic wait_wb();
    int k;
    for (k = 0; k < 100 && !mem_we; k++) @(negedge clk);
    check("reach_wb", 64'(mem_we), 64'd1);
  endtask

  task automatic load_add();
    clear_mem();
    mem[0] = ins(4'd0, 5, 6);
    mem[5] = 32'd7;
    mem[6] = 32'd9;
  endtask

  int  ill;
  bit  saw_req;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_status", {61'd0, halted, retired, illegal}, 64'd0);

    // ADD with zero wait states
    load_add();
    push(5, 32'd16);
    start();
    check("idle_no_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("first_fetch", {62'd0, mem_req, mem_we}, 64'd2);
    run(1, ill);
    check("add_cycle", 64'(last_wr_cyc - c0), 64'd4);
    check("add_pc", 64'(pc), 64'd1);
    check("add_illegal", 64'(ill), 64'd0);
    stop();
    check("add_mem", 64'(mem[5]), 64'd16);

    // Same program with two wait cycles per access
    load_add();
    wait_cfg = 2;
    push(5, 32'd16);
    start();
    run(1, ill);
    check("wait_cycle", 64'(last_wr_cyc - c0), 64'd12);
    check("wait_pc", 64'(pc), 64'd1);
    stop();
    wait_cfg = 0;

    // ALU mix including shift and compare boundaries
    clear_mem();
    mem[0] = ins(4'd4, 100, 101);  mem[100] = 32'h8000_0000; mem[101] = 32'd31;
    mem[1] = ins(4'd4, 102, 103);  mem[102] = 32'h8000_0000; mem[103] = 32'd33;
    mem[2] = ins(4'd7, 104, 3);    mem[104] = 32'd3;
    mem[3] = ins(4'd3, 105, 8'hFF); mem[105] = 32'h0F0F_0F0F;
    mem[4] = ins(4'd6, 106, 107);  mem[106] = 32'd2; mem[107] = 32'd3;
    mem[5] = ins(4'd8, 108, 100);
    mem[6] = ins(4'd9, 109, 16'h1234);
    mem[7] = ins(4'd5, 110, 4);    mem[110] = 32'h100;
    mem[8] = ins(4'd0, 111, 112);  mem[111] = 32'hFFFF_FFFF; mem[112] = 32'd2;
    mem[9] = ins(4'd2, 113, 114);  mem[113] = 32'hFF00_FF00; mem[114] = 32'h0FF0_0FF0;
    push(100, 32'd1);
    push(102, 32'd0);
    push(104, 32'd0);
    push(105, 32'hFFFF_FFF0);
    push(106, 32'd1);
    push(108, 32'd1);
    push(109, 32'h1234);
    push(110, 32'h10);
    push(111, 32'd1);
    push(113, 32'hF0FF_F0FF);
    start();
    run(10, ill);
    check("alu_pc", 64'(pc), 64'd10);
    stop();

    // CPI / CPIi indirection
    clear_mem();
    mem[0] = ins(4'd10, 11, 10);
    mem[1] = ins(4'd11, 10, 11);
    mem[2] = ins(4'd9, 11, 16'h55);
    mem[3] = ins(4'd11, 10, 11);
    mem[10] = 32'd20;
    mem[20] = 32'h0000_ABCD;
    push(11, 32'h0000_ABCD);
    push(20, 32'h0000_ABCD);
    push(11, 32'h55);
    push(20, 32'h55);
    start();
    run(4, ill);
    check("cpi_pc", 64'(pc), 64'd4);
    stop();
    check("cpi_mem20", 64'(mem[20]), 64'h55);

    // Branches and self-loop halt
    clear_mem();
    mem[0]  = ins(4'd12, 100, 101); mem[100] = 32'd40; mem[101] = 32'd0;
    mem[40] = ins(4'd12, 102, 103); mem[103] = 32'd1;
    mem[41] = ins(4'd9, 104, 7);
    mem[42] = ins(4'd13, 106, 2);   mem[106] = 32'd6;
    mem[8]  = ins(4'd13, 105, 3);   mem[105] = 32'd5;
    push(104, 32'd7);
    start();
    run(1, ill);
    check("bzj_taken_pc", 64'(pc), 64'd40);
    run(1, ill);
    check("bzj_not_taken_pc", 64'(pc), 64'd41);
    run(2, ill);
    check("bzji_pc", 64'(pc), 64'd8);
    run(1, ill);
    @(negedge clk);
    check("halted", 64'(halted), 64'd1);
    check("halt_pc", 64'(pc), 64'd8);
    saw_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) saw_req = 1'b1;
    end
    check("halt_no_req", 64'(saw_req), 64'd0);
    stop();

    // MUL / MULi
    clear_mem();
    mem[0] = ins(4'd14, 100, 101); mem[100] = 32'd6; mem[101] = 32'd7;
    mem[1] = ins(4'd15, 102, 5);   mem[102] = 32'h8000_0001;
`ifdef VSCPU_MUL_EN
    push(100, 32'd42);
    push(102, 32'h8000_0005);
`endif
    start();
    run(2, ill);
`ifdef VSCPU_MUL_EN
    check("mul_illegal", 64'(ill), 64'd0);
`else
    check("mul_illegal", 64'(ill), 64'd2);
`endif
    check("mul_pc", 64'(pc), 64'd2);
    stop();

    // Reset while a write is stalled, then reset coinciding with the ack
    load_add();
    block_wr = 1'b1;
    start();
    wait_wb();
    repeat (2) @(negedge clk);
    check("wb_held", {62'd0, mem_req, mem_we}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_req", 64'(mem_req), 64'd0);
    check("rst_drop_pc", 64'(pc), 64'd0);
    block_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_write", 64'(mem[5]), 64'd7);

    block_wr = 1'b1;
    start();
    wait_wb();
    rst = 1'b1;
    block_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack_no_write", 64'(mem[5]), 64'd7);
    check("rst_ack_pc", 64'(pc), 64'd0);
    stop();

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
